// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the exec_ctrl slice: ALU opcode and controller
// state enums, datapath widths and the opcode legality check.
package common_pkg;

   localparam int DataW    = 8;
   localparam int StatW    = 4;
   localparam int RegCount = 4;

   typedef enum logic [3:0] {
      OP_SLR = 4'h0,
      OP_SLL = 4'h1,
      OP_INC = 4'h4,
      OP_DEC = 4'h5,
      OP_ADD = 4'h6,
      OP_NOT = 4'h8,
      OP_AND = 4'h9,
      OP_OR  = 4'hA,
      OP_MOV = 4'hB
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_e;

   // Any opcode outside the ALU enum is executed as a NOP
   function automatic logic isLegalOp(input logic [3:0] op);
      logic legal;
      case (op)
         OP_SLR, OP_SLL, OP_INC, OP_DEC, OP_ADD,
         OP_NOT, OP_AND, OP_OR, OP_MOV: legal = 1'b1;
         default:                       legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// Instruction handshake plus the ALU-facing bus of exec_ctrl.
// slave = the controller, master = whoever feeds instructions and hosts the ALU.
interface exec_ctrl_if;
   import common_pkg::*;

   logic [DataW-1:0] instr_in;
   logic             instr_valid_in;
   logic             instr_ready_out;
   logic [DataW-1:0] a_out;
   logic [DataW-1:0] b_out;
   logic [3:0]       alu_op_out;
   logic [StatW-1:0] status_out;
   logic [DataW-1:0] result_in;
   logic [StatW-1:0] status_in;

   modport master (
      output instr_in, instr_valid_in, result_in, status_in,
      input  instr_ready_out, a_out, b_out, alu_op_out, status_out
   );

   modport slave (
      input  instr_in, instr_valid_in, result_in, status_in,
      output instr_ready_out, a_out, b_out, alu_op_out, status_out
   );

endinterface

// File: rtl/exec_ctrl_regfile.sv
// 4x8 register file: one write port, two operand read ports and one
// debug read port. Reads are combinational and see only committed values.
module regfile
   import common_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [1:0]       wr_addr_i,
   input  logic [DataW-1:0] wr_data_i,
   input  logic [1:0]       rd_a_addr_i,
   output logic [DataW-1:0] rd_a_data_o,
   input  logic [1:0]       rd_b_addr_i,
   output logic [DataW-1:0] rd_b_data_o,
   input  logic [1:0]       dbg_addr_i,
   output logic [DataW-1:0] dbg_data_o
);

   logic [DataW-1:0] regs_q [RegCount];

   // Single write port; every register clears on reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < RegCount; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_a_data_o = regs_q[rd_a_addr_i];
   assign rd_b_data_o = regs_q[rd_b_addr_i];
   assign dbg_data_o  = regs_q[dbg_addr_i];

endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: three-cycle IDLE -> EXEC -> WB instruction controller in front of
// an external ALU, with an external register-load port.
// Optional feature: define EXEC_CTRL_ILLEGAL_TRAP_EN to make an illegal opcode
// raise a sticky trap that blocks instructions and loads until reset.
module exec_ctrl
   import common_pkg::*;
(
   input  logic             clk_in,
   input  logic             rst_in,
   exec_ctrl_if.slave       bus,
   input  logic             ld_valid_in,
   input  logic [1:0]       ld_sel_in,
   input  logic [DataW-1:0] ld_data_in,
   input  logic [1:0]       rd_sel_in,
   output logic [DataW-1:0] rd_data_out,
   output logic             done_out,
   output logic             trap_out
);

   state_e           state_q;
   logic [3:0]       op_q;
   logic [1:0]       dst_q;
   logic [DataW-1:0] a_q;
   logic [DataW-1:0] b_q;
   logic [DataW-1:0] res_q;
   logic [StatW-1:0] stat_q;
   logic [StatW-1:0] s_q;
   logic             done_q;

   logic             accept;
   logic             loadEn;
   logic             wbWrite;
   logic             wrEn;
   logic [1:0]       wrAddr;
   logic [DataW-1:0] wrData;
   logic [DataW-1:0] dstData;
   logic [DataW-1:0] srcData;

`ifdef EXEC_CTRL_ILLEGAL_TRAP_EN
   logic             trap_q;
   assign trap_out = trap_q;
`else
   assign trap_out = 1'b0;
`endif

   assign bus.instr_ready_out = (state_q == ST_IDLE) && !ld_valid_in && !trap_out;
   assign accept  = bus.instr_valid_in && bus.instr_ready_out;
   assign loadEn  = (state_q == ST_IDLE) && ld_valid_in && !trap_out;
   assign wbWrite = (state_q == ST_WB) && isLegalOp(op_q);

   // Loads only happen in IDLE and writeback only in WB, so they never collide
   assign wrEn   = loadEn || wbWrite;
   assign wrAddr = wbWrite ? dst_q : ld_sel_in;
   assign wrData = wbWrite ? res_q : ld_data_in;

   regfile u_regfile (
      .clk_i       (clk_in),
      .rst_i       (rst_in),
      .we_i        (wrEn),
      .wr_addr_i   (wrAddr),
      .wr_data_i   (wrData),
      .rd_a_addr_i (bus.instr_in[3:2]),
      .rd_a_data_o (dstData),
      .rd_b_addr_i (bus.instr_in[1:0]),
      .rd_b_data_o (srcData),
      .dbg_addr_i  (rd_sel_in),
      .dbg_data_o  (rd_data_out)
   );

   // Controller FSM: latch operands on accept, capture ALU result in EXEC,
   // commit status and pulse done in WB
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         dst_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         stat_q  <= '0;
         s_q     <= '0;
         done_q  <= 1'b0;
`ifdef EXEC_CTRL_ILLEGAL_TRAP_EN
         trap_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q    <= bus.instr_in[7:4];
                  dst_q   <= bus.instr_in[3:2];
                  a_q     <= dstData;
                  b_q     <= srcData;
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               res_q   <= bus.result_in;
               stat_q  <= bus.status_in;
               done_q  <= 1'b1;
               state_q <= ST_WB;
            end
            ST_WB: begin
               if (isLegalOp(op_q)) begin
                  s_q <= stat_q;
               end
`ifdef EXEC_CTRL_ILLEGAL_TRAP_EN
               if (!isLegalOp(op_q)) begin
                  trap_q <= 1'b1;
               end
`endif
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.a_out      = a_q;
   assign bus.b_out      = b_q;
   assign bus.alu_op_out = op_q;
   assign bus.status_out = s_q;
   assign done_out       = done_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: a bench-side ALU, a transaction-level
// reference model, a per-cycle compare process, directed scenarios and a
// randomized phase. Honours EXEC_CTRL_ILLEGAL_TRAP_EN when defined.
module tb_exec_ctrl;

`ifdef EXEC_CTRL_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic       clk_in;
   logic       rst_in;
   logic       ld_valid_in;
   logic [1:0] ld_sel_in;
   logic [7:0] ld_data_in;
   logic [1:0] rd_sel_in;
   logic [7:0] rd_data_out;
   logic       done_out;
   logic       trap_out;

   exec_ctrl_if bus ();

   exec_ctrl dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .bus         (bus),
      .ld_valid_in (ld_valid_in),
      .ld_sel_in   (ld_sel_in),
      .ld_data_in  (ld_data_in),
      .rd_sel_in   (rd_sel_in),
      .rd_data_out (rd_data_out),
      .done_out    (done_out),
      .trap_out    (trap_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int passed = 0;
   int total  = 0;
   bit checkEn = 1'b0;

   // Reference ALU: returns {status[3:0], result[7:0]}; status = {neg, zero, carry, parity}
   function automatic logic [11:0] aluModel(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] w;
      case (op)
         4'h0:    w = {a[0], 1'b0, a[7:1]};
         4'h1:    w = {a, 1'b0};
         4'h4:    w = {1'b0, a} + 9'd1;
         4'h5:    w = {1'b0, a} - 9'd1;
         4'h6:    w = {1'b0, a} + {1'b0, b};
         4'h8:    w = {1'b0, ~a};
         4'h9:    w = {1'b0, a & b};
         4'hA:    w = {1'b0, a | b};
         4'hB:    w = {1'b0, b};
         default: w = {1'b0, a ^ b};
      endcase
      return {w[7], (w[7:0] == 8'h00), w[8], ^w[7:0], w[7:0]};
   endfunction

   function automatic bit legalOp(input logic [3:0] op);
      logic [15:0] mask;
      mask = 16'h0F73;
      return mask[op];
   endfunction

   // Bench ALU drives honest values only while an instruction is in EXEC
   logic [11:0] aluOut;
   logic        aluHonest = 1'b0;
   logic [7:0]  noiseRes  = 8'h00;
   logic [3:0]  noiseStat = 4'h0;
   assign aluOut        = aluModel(bus.alu_op_out, bus.a_out, bus.b_out);
   assign bus.result_in = aluHonest ? aluOut[7:0]  : noiseRes;
   assign bus.status_in = aluHonest ? aluOut[11:8] : noiseStat;

   // Transaction-level model: busy counts cycles left until writeback commits
   logic [7:0] mR [4];
   logic [3:0] mS;
   bit         mTrap;
   int         mBusy;
   logic [3:0] mOp;
   logic [1:0] mDst;
   logic [7:0] mA, mB, mRes;
   logic [3:0] mStat;

   function automatic void modelClear();
      for (int i = 0; i < 4; i++) mR[i] = 8'h00;
      mS = 4'h0; mTrap = 1'b0; mBusy = 0; mOp = 4'h0; mDst = 2'd0;
      mA = 8'h00; mB = 8'h00; mRes = 8'h00; mStat = 4'h0;
   endfunction

   function automatic void modelEdge();
      if (mBusy == 0) begin
         if (ld_valid_in && !mTrap) begin
            mR[ld_sel_in] = ld_data_in;
         end else if (bus.instr_valid_in && !ld_valid_in && !mTrap) begin
            mOp  = bus.instr_in[7:4];
            mDst = bus.instr_in[3:2];
            mA   = mR[bus.instr_in[3:2]];
            mB   = mR[bus.instr_in[1:0]];
            {mStat, mRes} = aluModel(mOp, mA, mB);
            mBusy = 2;
         end
      end else if (mBusy == 2) begin
         mBusy = 1;
      end else begin
         if (legalOp(mOp)) begin
            mR[mDst] = mRes;
            mS = mStat;
         end else if (TRAP) begin
            mTrap = 1'b1;
         end
         mBusy = 0;
      end
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      else passed++;
   endtask

   // Per-cycle comparison of every meaningful output against the model
   always @(negedge clk_in) begin
      if (checkEn) begin
         checkOutput("ready",  8'(bus.instr_ready_out), 8'((mBusy == 0) && !ld_valid_in && !mTrap));
         checkOutput("done",   8'(done_out),            8'(mBusy == 1));
         checkOutput("trap",   8'(trap_out),            8'(mTrap));
         checkOutput("rdData", rd_data_out,             mR[rd_sel_in]);
         checkOutput("status", 8'(bus.status_out),      8'(mS));
         checkOutput("aOut",   bus.a_out,               mA);
         checkOutput("bOut",   bus.b_out,               mB);
         checkOutput("aluOp",  8'(bus.alu_op_out),      8'(mOp));
      end
   end

   task automatic tick();
      @(posedge clk_in);
      if (!rst_in) modelEdge();
      #1;
      aluHonest = (mBusy == 2);
      noiseRes  = 8'($urandom);
      noiseStat = 4'($urandom);
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] ins, input logic ld,
                                input logic [1:0] sel, input logic [7:0] data, input logic [1:0] rs);
      bus.instr_valid_in = v;
      bus.instr_in       = ins;
      ld_valid_in        = ld;
      ld_sel_in          = sel;
      ld_data_in         = data;
      rd_sel_in          = rs;
      tick();
   endtask

   task automatic applyReset();
      bus.instr_valid_in = 1'b0;
      ld_valid_in        = 1'b0;
      rst_in             = 1'b1;
      modelClear();
      tick();
      rst_in = 1'b0;
   endtask

   task automatic readReg(input logic [1:0] sel, input logic [7:0] exp, input string name);
      rd_sel_in = sel;
      #1;
      checkOutput(name, rd_data_out, exp);
      checkOutput({name, " model"}, mR[sel], exp);
   endtask

   initial begin
      rst_in = 1'b0; ld_valid_in = 1'b0; ld_sel_in = 2'd0; ld_data_in = 8'h00; rd_sel_in = 2'd0;
      bus.instr_valid_in = 1'b0; bus.instr_in = 8'h00;
      modelClear();
      #2 rst_in = 1'b1;
      #1 checkEn = 1'b1;
      tick();
      rst_in = 1'b0;

      // Reset state on every debug read port selection
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 2'(i));
         #1;
         checkOutput("rst rdData", rd_data_out, 8'h00);
         checkOutput("rst ready",  8'(bus.instr_ready_out), 8'h01);
         checkOutput("rst done",   8'(done_out), 8'h00);
      end

      // ADD R0,R1 with R0=0x11, R1=0xCF
      applyStimulus(1'b0, 8'h00, 1'b1, 2'd0, 8'h11, 2'd0);
      applyStimulus(1'b0, 8'h00, 1'b1, 2'd1, 8'hCF, 2'd1);
      applyStimulus(1'b1, 8'h61, 1'b0, 2'd0, 8'h00, 2'd0);
      #1;
      checkOutput("add exec ready", 8'(bus.instr_ready_out), 8'h00);
      checkOutput("add exec done",  8'(done_out), 8'h00);
      applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 2'd0);
      #1;
      checkOutput("add wb ready", 8'(bus.instr_ready_out), 8'h00);
      checkOutput("add wb done",  8'(done_out), 8'h01);
      applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 2'd0);
      readReg(2'd0, 8'hE0, "add R0");
      checkOutput("add status", 8'(bus.status_out), 8'h09);
      checkOutput("add status model", 8'(mS), 8'h09);
      checkOutput("add idle done", 8'(done_out), 8'h00);

      // MOV R1,R0 with R0=0x11
      applyStimulus(1'b0, 8'h00, 1'b1, 2'd0, 8'h11, 2'd0);
      applyStimulus(1'b1, 8'hB4, 1'b0, 2'd0, 8'h00, 2'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 2'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 2'd0);
      readReg(2'd1, 8'h11, "mov R1");
      readReg(2'd0, 8'h11, "mov R0");

      // Load and instruction together: load wins, instruction waits
      applyStimulus(1'b1, 8'h6B, 1'b1, 2'd2, 8'h5A, 2'd2);
      #1 checkOutput("ldprio ready", 8'(bus.instr_ready_out), 8'h00);
      applyStimulus(1'b1, 8'h6B, 1'b1, 2'd2, 8'h5A, 2'd2);
      readReg(2'd2, 8'h5A, "ldprio R2");
      applyStimulus(1'b1, 8'h6B, 1'b0, 2'd0, 8'h00, 2'd2);
      #1 checkOutput("ldprio accepted", 8'(bus.instr_ready_out), 8'h00);
      applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 2'd2);
      applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 2'd2);

      // Reset while ADD R0,R1 is in EXEC
      applyStimulus(1'b1, 8'h61, 1'b0, 2'd0, 8'h00, 2'd0);
      applyReset();
      readReg(2'd0, 8'h00, "rstexec R0");
      checkOutput("rstexec ready", 8'(bus.instr_ready_out), 8'h01);
      applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 2'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 2'd0);
      readReg(2'd0, 8'h00, "rstexec R0 later");

      // Illegal opcode 0x20: NOP with done pulse, trap when enabled
      applyStimulus(1'b0, 8'h00, 1'b1, 2'd0, 8'h33, 2'd0);
      applyStimulus(1'b1, 8'h20, 1'b0, 2'd0, 8'h00, 2'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 2'd0);
      #1 checkOutput("illegal done", 8'(done_out), 8'h01);
      applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 2'd0);
      readReg(2'd0, 8'h33, "illegal R0");
      checkOutput("illegal trap",  8'(trap_out), 8'(TRAP));
      checkOutput("illegal ready", 8'(bus.instr_ready_out), 8'(!TRAP));
      applyStimulus(1'b0, 8'h00, 1'b1, 2'd0, 8'h77, 2'd0);
      readReg(2'd0, TRAP ? 8'h33 : 8'h77, "illegal load");
      applyReset();
      checkOutput("trap cleared", 8'(trap_out), 8'h00);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         if (($urandom_range(0, 99) == 0) || (mTrap && ($urandom_range(0, 3) == 0))) begin
            applyReset();
         end else begin
            applyStimulus(1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
                          2'($urandom), 8'($urandom), 2'($urandom));
         end
      end

      applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 2'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 2'd0);
      checkEn = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
